// File: rtl/scene_transition_pkg.sv
// Shared mode and state encodings for the scene-transition overlay.
package scene_transition_pkg;

  localparam logic [1:0] MODE_HWIPE  = 2'd0;
  localparam logic [1:0] MODE_VWIPE  = 2'd1;
  localparam logic [1:0] MODE_IRIS   = 2'd2;
  localparam logic [1:0] MODE_BLINDS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COVER   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_UNCOVER = 2'd3
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags, registered read data and sticky overflow.
module sync_fifo #(
  parameter int pFifoDepth  = 16,
  parameter int pColorDepth = 16
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iWe,
  input  logic [pColorDepth-1:0] iWd,
  input  logic                   iRe,
  output logic                   oRvld,
  output logic [pColorDepth-1:0] oRd,
  output logic                   oFull,
  output logic                   oEmp,
  output logic                   oOvf
);

  localparam int AW = $clog2(pFifoDepth);

  logic [pColorDepth-1:0] mem [pFifoDepth];
  logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic                   full_q, full_d, emp_q, emp_d, ovf_q, ovf_d, rvld_q, rvld_d;
  logic [pColorDepth-1:0] rd_q, rd_d;
  logic                   do_rd, do_wr;

  // A write into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    do_rd  = iRe & ~emp_q;
    do_wr  = iWe & (~full_q | do_rd);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + AW'(1);
    if (do_rd) rptr_d = rptr_q + AW'(1);
    cnt_d  = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    full_d = (cnt_d == (AW+1)'(pFifoDepth));
    emp_d  = (cnt_d == '0);
    ovf_d  = ovf_q | (iWe & full_q & ~do_rd);
    rvld_d = do_rd;
    rd_d   = do_rd ? mem[rptr_q] : rd_q;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      emp_q  <= 1'b1;
      ovf_q  <= 1'b0;
      rvld_q <= 1'b0;
      rd_q   <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      emp_q  <= emp_d;
      ovf_q  <= ovf_d;
      rvld_q <= rvld_d;
      rd_q   <= rd_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (do_wr) mem[wptr_q] <= iWd;
  end

  assign oRvld = rvld_q;
  assign oRd   = rd_q;
  assign oFull = full_q;
  assign oEmp  = emp_q;
  assign oOvf  = ovf_q;

endmodule

// File: rtl/scene_transition_gen.sv
// Frame-synchronous transition overlay: cover/hold/uncover FSM, per-pixel cover test, output FIFO.
// Handshake: a source beat is taken on iEds; a sink pop happens on iEdd while !oEmp, oVdd/oDd follow one cycle later.
module scene_transition_gen
  import scene_transition_pkg::*;
#(
  parameter int pHdisplayWidth = 11,
  parameter int pVdisplayWidth = 11,
  parameter int pColorDepth    = 16,
  parameter int pFifoDepth     = 16,
  parameter int pBandBits      = 4,
  parameter int pHoldBits      = 8,
  localparam int pProgWidth    = ((pHdisplayWidth > pVdisplayWidth) ? pHdisplayWidth : pVdisplayWidth) + 1
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iStart,
  input  logic [1:0]                iMode,
  input  logic [pHdisplayWidth-1:0] iStep,
  input  logic [pHoldBits-1:0]      iHoldFrames,
  input  logic [pColorDepth-1:0]    iColor,
  input  logic [pColorDepth-1:0]    iPixel,
  input  logic [pHdisplayWidth-1:0] iHdisplay,
  input  logic [pVdisplayWidth-1:0] iVdisplay,
  input  logic [pHdisplayWidth-1:0] iHpos,
  input  logic [pVdisplayWidth-1:0] iVpos,
  input  logic                      iFe,
  input  logic                      iEds,
  output logic                      oFull,
  output logic                      oVdd,
  output logic [pColorDepth-1:0]    oDd,
  input  logic                      iEdd,
  output logic                      oEmp,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oOvf,
  output logic [1:0]                oState,
  output logic [pProgWidth-1:0]     oProg
);

  localparam int PW = pProgWidth;

  state_e                   state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic [PW-1:0]            step_q, step_d;
  logic [PW-1:0]            limit_q, limit_d;
  logic [PW-1:0]            prog_q, prog_d;
  logic [pHoldBits-1:0]     hold_frames_q, hold_frames_d;
  logic [pHoldBits-1:0]     hold_cnt_q, hold_cnt_d;
  logic                     done_q, done_d;
  logic [pColorDepth-1:0]   pix_q, pix_d;
  logic                     we_q, we_d;

  logic [PW-1:0]            hd_ext, vd_ext, x_ext, y_ext, max_dim, start_limit;
  logic [PW:0]              sum_up;
  logic                     covered;

  always_comb begin
    hd_ext  = PW'(iHdisplay);
    vd_ext  = PW'(iVdisplay);
    x_ext   = PW'(iHpos);
    y_ext   = PW'(iVpos);
    max_dim = (hd_ext > vd_ext) ? hd_ext : vd_ext;
    case (iMode)
      MODE_HWIPE:  start_limit = hd_ext;
      MODE_VWIPE:  start_limit = vd_ext;
      MODE_IRIS:   start_limit = max_dim >> 1;
      default:     start_limit = PW'(2 ** pBandBits);
    endcase
    sum_up = {1'b0, prog_q} + {1'b0, step_q};
  end

  // Right/bottom edges use x+P >= H so a progress larger than the screen still reads as covered.
  always_comb begin
    covered = 1'b0;
    if (state_q != ST_IDLE) begin
      case (mode_q)
        MODE_HWIPE: covered = (x_ext < prog_q);
        MODE_VWIPE: covered = (y_ext < prog_q);
        MODE_IRIS:  covered = (x_ext < prog_q) || (y_ext < prog_q) ||
                              (({1'b0, x_ext} + {1'b0, prog_q}) >= {1'b0, hd_ext}) ||
                              (({1'b0, y_ext} + {1'b0, prog_q}) >= {1'b0, vd_ext});
        default:    covered = (PW'(iHpos[pBandBits-1:0]) < prog_q);
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    step_d        = step_q;
    limit_d       = limit_q;
    prog_d        = prog_q;
    hold_frames_d = hold_frames_q;
    hold_cnt_d    = hold_cnt_q;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          state_d       = ST_COVER;
          mode_d        = iMode;
          step_d        = (iStep == '0) ? PW'(1) : PW'(iStep);
          limit_d       = start_limit;
          hold_frames_d = iHoldFrames;
          prog_d        = '0;
        end
      end
      ST_COVER: begin
        if (iFe) begin
          if (sum_up >= {1'b0, limit_q}) begin
            prog_d     = limit_q;
            state_d    = ST_HOLD;
            hold_cnt_d = hold_frames_q;
          end else begin
            prog_d = sum_up[PW-1:0];
          end
        end
      end
      ST_HOLD: begin
        if (iFe) begin
          if (hold_cnt_q == '0) state_d = ST_UNCOVER;
          else                  hold_cnt_d = hold_cnt_q - pHoldBits'(1);
        end
      end
      default: begin
        if (iFe) begin
          if (prog_q <= step_q) begin
            prog_d  = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            prog_d = prog_q - step_q;
          end
        end
      end
    endcase
    we_d  = iEds;
    pix_d = iEds ? (covered ? iColor : iPixel) : pix_q;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_HWIPE;
      step_q        <= PW'(1);
      limit_q       <= '0;
      prog_q        <= '0;
      hold_frames_q <= '0;
      hold_cnt_q    <= '0;
      done_q        <= 1'b0;
      pix_q         <= '0;
      we_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      step_q        <= step_d;
      limit_q       <= limit_d;
      prog_q        <= prog_d;
      hold_frames_q <= hold_frames_d;
      hold_cnt_q    <= hold_cnt_d;
      done_q        <= done_d;
      pix_q         <= pix_d;
      we_q          <= we_d;
    end
  end

  sync_fifo #(
    .pFifoDepth  (pFifoDepth),
    .pColorDepth (pColorDepth)
  ) u_fifo (
    .iClk  (iClk),
    .iRst  (iRst),
    .iWe   (we_q),
    .iWd   (pix_q),
    .iRe   (iEdd),
    .oRvld (oVdd),
    .oRd   (oDd),
    .oFull (oFull),
    .oEmp  (oEmp),
    .oOvf  (oOvf)
  );

  assign oBusy  = (state_q != ST_IDLE);
  assign oDone  = done_q;
  assign oState = state_q;
  assign oProg  = prog_q;

endmodule
